// File: rtl/hoplite_router_nd_if.sv
// Ring, eject, injection and statistics signals of one hoplite_router_nd node.
// The router uses the slave modport; the ring/PE side uses the master modport.
interface hoplite_router_nd_if #(
    parameter int unsigned FLIT_SIZE = 128,
    parameter int unsigned NUM_DIMS  = 3,
    parameter int unsigned INJ_DEPTH = 4,
    parameter int unsigned CNT_WIDTH = 16
);
    logic [NUM_DIMS-1:0]                in_valid;
    logic [NUM_DIMS*FLIT_SIZE-1:0]      in_flit;
    logic [NUM_DIMS-1:0]                out_valid;
    logic [NUM_DIMS*FLIT_SIZE-1:0]      out_flit;
    logic                               inj_valid;
    logic [FLIT_SIZE-1:0]               inj_flit;
    logic                               inj_ready;
    logic                               inj_sent;
    logic [NUM_DIMS-1:0]                eject_valid;
    logic [NUM_DIMS*FLIT_SIZE-1:0]      eject_flit;
    logic [$clog2(INJ_DEPTH):0]         inj_count;
    logic [CNT_WIDTH-1:0]               deflect_count;
    logic [CNT_WIDTH-1:0]               inject_count;

    modport master (
        output in_valid, in_flit, inj_valid, inj_flit,
        input  out_valid, out_flit, inj_ready, inj_sent,
               eject_valid, eject_flit, inj_count, deflect_count, inject_count
    );

    modport slave (
        input  in_valid, in_flit, inj_valid, inj_flit,
        output out_valid, out_flit, inj_ready, inj_sent,
               eject_valid, eject_flit, inj_count, deflect_count, inject_count
    );
endinterface

// File: rtl/hoplite_router_nd.sv
// N-dimensional Hoplite deflection router: dimension-ordered routing over NUM_DIMS
// unidirectional rings, per-dim eject ports, PE injection FIFO and saturating stats.
module hoplite_router_nd #(
    parameter int unsigned                     FLIT_SIZE     = 128,
    parameter int unsigned                     ADDRESS_WIDTH = 3,
    parameter int unsigned                     NUM_DIMS      = 3,
    parameter logic [NUM_DIMS*ADDRESS_WIDTH-1:0] CUR_COORD   = '0,
    parameter int unsigned                     INJ_DEPTH     = 4,
    parameter int unsigned                     CNT_WIDTH     = 16
) (
    input  logic               clk,
    input  logic               rst,
    hoplite_router_nd_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(INJ_DEPTH);
    localparam int unsigned OCC_W = $clog2(INJ_DEPTH) + 1;

    logic [NUM_DIMS-1:0][FLIT_SIZE-1:0] in_f;
    logic [NUM_DIMS-1:0][NUM_DIMS-1:0]  m;     // m[d][k]: in_d destination matches in dim k
    logic [NUM_DIMS-1:0][NUM_DIMS-1:0]  treq;  // treq[d][j]: in_d requests a turn onto output j
    logic [NUM_DIMS-1:0]                is_ej, is_cont, is_turn, refused;
    logic                               all_hi, tfound, granted, hfound, sent, push;
    int unsigned                        j;
    logic [FLIT_SIZE-1:0]               head;
    logic [NUM_DIMS-1:0]                hm;
    logic [CNT_WIDTH:0]                 dsum, isum;

    logic [NUM_DIMS-1:0]                out_valid_q, out_valid_d;
    logic [NUM_DIMS-1:0][FLIT_SIZE-1:0] out_flit_q, out_flit_d;
    logic [NUM_DIMS-1:0]                ej_valid_q, ej_valid_d;
    logic [NUM_DIMS-1:0][FLIT_SIZE-1:0] ej_flit_q, ej_flit_d;
    logic                               inj_sent_q, inj_sent_d;
    logic [INJ_DEPTH-1:0][FLIT_SIZE-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]                   occ_q, occ_d;
    logic [CNT_WIDTH-1:0]               deflect_q, deflect_d, inject_q, inject_d;

    assign in_f = bus.in_flit;

    always_comb begin
        m       = '0;
        treq    = '0;
        is_ej   = '0;
        is_cont = '0;
        is_turn = '0;
        all_hi  = 1'b0;
        tfound  = 1'b0;
        for (int unsigned d = 0; d < NUM_DIMS; d++) begin
            for (int unsigned k = 0; k < NUM_DIMS; k++)
                m[d][k] = (in_f[d][k*ADDRESS_WIDTH +: ADDRESS_WIDTH] ==
                           CUR_COORD[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
            all_hi = 1'b1;
            for (int unsigned k = d; k < NUM_DIMS; k++)
                all_hi = all_hi & m[d][k];
            is_ej[d]   = bus.in_valid[d] & all_hi;
            is_cont[d] = bus.in_valid[d] & ~m[d][d];
            is_turn[d] = bus.in_valid[d] & m[d][d] & ~all_hi;
            tfound = 1'b0;
            for (int unsigned k = d + 1; k < NUM_DIMS; k++) begin
                if (!tfound && !m[d][k]) begin
                    tfound     = 1'b1;
                    treq[d][k] = is_turn[d];
                end
            end
        end
    end

    always_comb begin
        out_valid_d = '0;
        out_flit_d  = out_flit_q;
        ej_valid_d  = is_ej;
        ej_flit_d   = ej_flit_q;
        refused     = '0;
        granted     = 1'b0;
        hfound      = 1'b0;
        sent        = 1'b0;
        hm          = '0;
        j           = 0;
        for (int unsigned d = 0; d < NUM_DIMS; d++)
            if (is_ej[d]) ej_flit_d[d] = in_f[d];

        // Outputs resolved top-down so a refused turner is known before its own output is decided.
        for (int unsigned jj = 0; jj < NUM_DIMS; jj++) begin
            j       = NUM_DIMS - 1 - jj;
            granted = is_cont[j] | (is_turn[j] & refused[j]);
            if (granted) begin
                out_valid_d[j] = 1'b1;
                out_flit_d[j]  = in_f[j];
            end
            for (int unsigned d = 0; d < NUM_DIMS; d++) begin
                if (d < j && treq[d][j]) begin
                    if (!granted) begin
                        granted        = 1'b1;
                        out_valid_d[j] = 1'b1;
                        out_flit_d[j]  = in_f[d];
                    end else begin
                        refused[d] = 1'b1;
                    end
                end
            end
        end

        head = fifo_q[rd_ptr_q];
        for (int unsigned k = 0; k < NUM_DIMS; k++)
            hm[k] = (head[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] ==
                     CUR_COORD[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
        if (occ_q != '0) begin
            if (&hm) begin
                if (!is_ej[0]) begin
                    sent          = 1'b1;
                    ej_valid_d[0] = 1'b1;
                    ej_flit_d[0]  = head;
                end
            end else begin
                for (int unsigned k = 0; k < NUM_DIMS; k++) begin
                    if (!hfound && !hm[k]) begin
                        hfound = 1'b1;
                        if (!out_valid_d[k]) begin
                            sent           = 1'b1;
                            out_valid_d[k] = 1'b1;
                            out_flit_d[k]  = head;
                        end
                    end
                end
            end
        end
        inj_sent_d = sent;

        push     = bus.inj_valid & (occ_q != OCC_W'(INJ_DEPTH));
        fifo_d   = fifo_q;
        if (push) fifo_d[wr_ptr_q] = bus.inj_flit;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = sent ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, sent})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        dsum = {1'b0, deflect_q};
        for (int unsigned d = 0; d < NUM_DIMS; d++)
            dsum = dsum + (CNT_WIDTH+1)'(refused[d]);
        deflect_d = dsum[CNT_WIDTH] ? '1 : dsum[CNT_WIDTH-1:0];
        isum      = {1'b0, inject_q} + (CNT_WIDTH+1)'(sent);
        inject_d  = isum[CNT_WIDTH] ? '1 : isum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= '0;
            out_flit_q  <= '0;
            ej_valid_q  <= '0;
            ej_flit_q   <= '0;
            inj_sent_q  <= 1'b0;
            fifo_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            deflect_q   <= '0;
            inject_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            ej_valid_q  <= ej_valid_d;
            ej_flit_q   <= ej_flit_d;
            inj_sent_q  <= inj_sent_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            deflect_q   <= deflect_d;
            inject_q    <= inject_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_flit      = out_flit_q;
    assign bus.eject_valid   = ej_valid_q;
    assign bus.eject_flit    = ej_flit_q;
    assign bus.inj_sent      = inj_sent_q;
    assign bus.inj_count     = occ_q;
    assign bus.inj_ready     = (occ_q != OCC_W'(INJ_DEPTH));
    assign bus.deflect_count = deflect_q;
    assign bus.inject_count  = inject_q;
endmodule
